// File: rtl/iir_pkg.sv
// Shared widths and fixed-point constants for the first-order IIR filter.
package iir_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 15;
  localparam int DEF_ACC_W  = 34;

  localparam int SAT_MAX    = 32767;
  localparam int SAT_MIN    = -32768;
  localparam int ROUND_BIAS = 1 << (DEF_FRAC_W - 1);
endpackage

// File: rtl/iir_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of the accumulator.
// Zero latency; no flow control.
module iir_round_sat
  import iir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] res
);
  localparam logic signed [ACC_W-1:0] BIAS_EXT = ACC_W'(ROUND_BIAS);
  localparam logic signed [ACC_W-1:0] MAX_EXT  = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] MIN_EXT  = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;

  // Headroom in ACC_W guarantees the bias add cannot wrap.
  assign biased  = acc + BIAS_EXT;
  assign shifted = biased >>> FRAC_W;

  always_comb begin
    res = shifted[DATA_W-1:0];
    if (shifted > MAX_EXT) begin
      res = DATA_W'(SAT_MAX);
    end else if (shifted < MIN_EXT) begin
      res = DATA_W'(SAT_MIN);
    end
  end
endmodule

// File: rtl/iir.sv
// First-order DF-I IIR y = b0*x + b1*x_d + a1*y, Q1.15; registered y, 1-cycle latency.
// No backpressure: one sample accepted and produced every clock.
module iir
  import iir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] b0,
  input  logic signed [DATA_W-1:0] b1,
  input  logic signed [DATA_W-1:0] a1,
  input  logic                     rst,
  input  logic                     clk,
  output logic signed [DATA_W-1:0] y
);
  logic signed [DATA_W-1:0]   x_d;
  logic signed [2*DATA_W-1:0] p_b0;
  logic signed [2*DATA_W-1:0] p_b1;
  logic signed [2*DATA_W-1:0] p_a1;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   y_next;

  assign p_b0 = x   * b0;
  assign p_b1 = x_d * b1;
  assign p_a1 = y   * a1;

  // Sign-extend each product before summing so all three fit without wrap.
  assign acc = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_a1);

  iir_round_sat #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .ACC_W (ACC_W)
  ) u_round_sat (
    .acc(acc),
    .res(y_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_d <= '0;
      y   <= '0;
    end else begin
      x_d <= x;
      y   <= y_next;
    end
  end
endmodule

// File: tb/tb_iir.sv
// Directed, table-driven bench for the first-order IIR filter.
module tb_iir;
  logic               clk;
  logic               rst;
  logic signed [15:0] x;
  logic signed [15:0] b0;
  logic signed [15:0] b1;
  logic signed [15:0] a1;
  logic signed [15:0] y;

  int checks;
  int errors;

  typedef struct {
    string              name;
    logic               rst;
    logic signed [15:0] x;
    logic signed [15:0] b0;
    logic signed [15:0] b1;
    logic signed [15:0] a1;
    logic signed [15:0] y_exp;
  } vec_t;

  vec_t vecs[$];

  iir dut (
    .x  (x),
    .b0 (b0),
    .b1 (b1),
    .a1 (a1),
    .rst(rst),
    .clk(clk),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input string name, input logic r, input int xv,
                              input int c0, input int c1, input int ca, input int ye);
    vec_t v;
    v.name  = name;
    v.rst   = r;
    v.x     = 16'(xv);
    v.b0    = 16'(c0);
    v.b1    = 16'(c1);
    v.a1    = 16'(ca);
    v.y_exp = 16'(ye);
    vecs.push_back(v);
  endfunction

  task automatic apply(input logic r, input logic signed [15:0] xv,
                       input logic signed [15:0] c0, input logic signed [15:0] c1,
                       input logic signed [15:0] ca);
    rst = r;
    x   = xv;
    b0  = c0;
    b1  = c1;
    a1  = ca;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [15:0] exp);
    checks++;
    if (y !== exp) begin
      errors++;
      $display("FAIL %s: y=%0d expected %0d", name, y, exp);
    end
  endtask

  localparam int C  = 1546;
  localparam int A  = 1044;
  localparam int MX = 32767;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    x   = '0;
    b0  = '0;
    b1  = '0;
    a1  = '0;

    // Reset with junk input, then quiet input must keep y at zero.
    add("rst0",  1, 12345, C, C, A, 0);
    add("rst1",  1, -777,  C, C, A, 0);
    add("idle0", 0, 0,     C, C, A, 0);
    add("idle1", 0, 0,     C, C, A, 0);
    // Impulse: the tail rounds 25*1044/32768 = 0.797 up to 1 before decaying.
    add("imp0",  0, 16384, C, C, A, 773);
    add("imp1",  0, 0,     C, C, A, 798);
    add("imp2",  0, 0,     C, C, A, 25);
    add("imp3",  0, 0,     C, C, A, 1);
    add("imp4",  0, 0,     C, C, A, 0);
    add("imp5",  0, 0,     C, C, A, 0);
    // Step from a clean state.
    add("step0", 0, 16384, C, C, A, 773);
    add("step1", 0, 16384, C, C, A, 1571);
    add("step2", 0, 16384, C, C, A, 1596);
    add("step3", 0, 16384, C, C, A, 1597);
    add("step4", 0, 16384, C, C, A, 1597);
    add("step5", 0, 16384, C, C, A, 1597);
    // Positive saturation.
    add("prst",  1, 0,     MX, MX, MX, 0);
    add("psat0", 0, MX,    MX, MX, MX, 32766);
    add("psat1", 0, MX,    MX, MX, MX, 32767);
    add("psat2", 0, MX,    MX, MX, MX, 32767);
    add("psat3", 0, MX,    MX, MX, MX, 32767);
    // Negative saturation.
    add("nrst",  1, 0,      MX, MX, 0, 0);
    add("nsat0", 0, -32768, MX, MX, 0, -32767);
    add("nsat1", 0, -32768, MX, MX, 0, -32768);
    add("nsat2", 0, -32768, MX, MX, 0, -32768);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].x, vecs[i].b0, vecs[i].b1, vecs[i].a1);
      check(vecs[i].name, vecs[i].y_exp);
    end

    // Mid-stream reset during a step clears both x_d and y history.
    apply(1'b1, 16'sd0, 16'(C), 16'(C), 16'(A));
    check("mrst_pre", 16'sd0);
    apply(1'b0, 16'sd16384, 16'(C), 16'(C), 16'(A));
    check("mid0", 16'sd773);
    apply(1'b0, 16'sd16384, 16'(C), 16'(C), 16'(A));
    check("mid1", 16'sd1571);
    apply(1'b0, 16'sd16384, 16'(C), 16'(C), 16'(A));
    check("mid2", 16'sd1596);
    apply(1'b1, 16'sd16384, 16'(C), 16'(C), 16'(A));
    check("mid_rst", 16'sd0);
    apply(1'b0, 16'sd16384, 16'(C), 16'(C), 16'(A));
    check("resume0", 16'sd773);
    apply(1'b0, 16'sd16384, 16'(C), 16'(C), 16'(A));
    check("resume1", 16'sd1571);
    apply(1'b0, 16'sd16384, 16'(C), 16'(C), 16'(A));
    check("resume2", 16'sd1596);

    // Coefficient change lands on the very next edge: b0 only, from clean state.
    apply(1'b1, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
    apply(1'b0, 16'sd16384, 16'sd16384, 16'sd0, 16'sd0);
    check("coef0", 16'sd8192);
    apply(1'b0, 16'sd16384, -16'sd16384, 16'sd0, 16'sd0);
    check("coef1", -16'sd8192);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
